// File: rtl/sram_pkg.sv
// Shared widths, counter type and pin-decode helpers for the asynchronous SRAM
// responder model.
package sram_pkg;

    localparam int SRAM_ADDR_W      = 18;
    localparam int SRAM_DATA_W      = 16;
    localparam int SRAM_LANE_W      = 8;
    localparam int READ_LAT_DEFAULT = 1;
    localparam int CNT_W            = 16;

    typedef logic [SRAM_DATA_W-1:0] sram_data_t;
    typedef logic [CNT_W-1:0]       sram_cnt_t;

    // One decoded view of the control pins for the current cycle.
    typedef struct packed {
        logic wr;
        logic rd;
        logic conflict;
    } sram_cmd_t;

    function automatic sram_cmd_t decode_cmd(input logic ce_n, input logic we_n, input logic oe_n);
        sram_cmd_t cmd;
        cmd.wr       = ~ce_n & ~we_n;
        cmd.rd       = ~ce_n &  we_n & ~oe_n;
        cmd.conflict = ~ce_n & ~we_n & ~oe_n;
        return cmd;
    endfunction

    function automatic sram_cnt_t sat_inc(input sram_cnt_t cnt, input logic en);
        return (en && (cnt != '1)) ? cnt + CNT_W'(1) : cnt;
    endfunction

endpackage

// File: rtl/sram_responder_if.sv
// Controller-side SRAM address/control pins; the shared data bus stays a
// separate inout port on the responder.
interface sram_responder_if;
    import sram_pkg::*;

    logic [SRAM_ADDR_W-1:0] SRAM_ADDR;
    logic                   SRAM_UB_N;
    logic                   SRAM_LB_N;
    logic                   SRAM_WE_N;
    logic                   SRAM_CE_N;
    logic                   SRAM_OE_N;

    modport master (
        output SRAM_ADDR, SRAM_UB_N, SRAM_LB_N, SRAM_WE_N, SRAM_CE_N, SRAM_OE_N
    );

    modport slave (
        input SRAM_ADDR, SRAM_UB_N, SRAM_LB_N, SRAM_WE_N, SRAM_CE_N, SRAM_OE_N
    );

endinterface

// File: rtl/sram_resp_array.sv
// Byte-lane word storage: one write port with per-lane enables and one
// registered read port sharing the same word address.
module sram_resp_array
    import sram_pkg::*;
#(
    parameter int AW = 12
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [1:0]    lane_we_i,
    input  logic [AW-1:0] addr_i,
    input  sram_data_t    wdata_i,
    input  logic          re_i,
    output sram_data_t    rdata_o
);

    localparam int DEPTH = 1 << AW;

    logic [SRAM_LANE_W-1:0] mem_hi [DEPTH];
    logic [SRAM_LANE_W-1:0] mem_lo [DEPTH];
    sram_data_t             rdata_q;

    // NOTE: storage and read register carry no reset so the array maps onto
    // plain RAM; contents must survive rst and only pipeline valids are cleared.
    always_ff @(posedge clk) begin
        if (we_i && lane_we_i[1]) begin
            mem_hi[addr_i] <= wdata_i[SRAM_DATA_W-1:SRAM_LANE_W];
        end
        if (we_i && lane_we_i[0]) begin
            mem_lo[addr_i] <= wdata_i[SRAM_LANE_W-1:0];
        end
        if (re_i) begin
            rdata_q <= {mem_hi[addr_i], mem_lo[addr_i]};
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/sram_responder.sv
// Behavioural-accurate responder for an asynchronous 16-bit SRAM bus: samples
// pins on clk, returns read data after READ_LAT edges and counts traffic.
module sram_responder
    import sram_pkg::*;
#(
    parameter int MEM_AW   = 12,
    parameter int READ_LAT = READ_LAT_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst,
    sram_responder_if.slave        bus,
    inout  wire  [SRAM_DATA_W-1:0] SRAM_DQ,
    output sram_cnt_t              rd_count,
    output sram_cnt_t              wr_count,
    output logic                   contention_err
);

    sram_cmd_t           cmd;
    logic                wr_en;
    logic                drive_en;
    logic [MEM_AW-1:0]   word_addr;
    logic                unused_addr_hi;
    sram_data_t          arr_rdata;
    sram_data_t          pipe_out;

    logic [READ_LAT-1:0] rd_vld_q, rd_vld_d;
    sram_data_t          dq_q, dq_d;
    sram_cnt_t           rd_count_q, rd_count_d;
    sram_cnt_t           wr_count_q, wr_count_d;
    logic                err_q, err_d;

    assign cmd            = decode_cmd(bus.SRAM_CE_N, bus.SRAM_WE_N, bus.SRAM_OE_N);
    assign word_addr      = bus.SRAM_ADDR[MEM_AW-1:0];
    assign unused_addr_hi = ^bus.SRAM_ADDR[SRAM_ADDR_W-1:MEM_AW];
    // The array has no reset, so writes must be blocked explicitly while rst is low.
    assign wr_en          = cmd.wr & rst;

    sram_resp_array #(
        .AW (MEM_AW)
    ) u_array (
        .clk       (clk),
        .we_i      (wr_en),
        .lane_we_i ({~bus.SRAM_UB_N, ~bus.SRAM_LB_N}),
        .addr_i    (word_addr),
        .wdata_i   (SRAM_DQ),
        .re_i      (cmd.rd),
        .rdata_o   (arr_rdata)
    );

    // Array read register is stage 0; extra latency is a data-only delay line
    // whose slots are qualified by rd_vld_q.
    if (READ_LAT == 1) begin : g_lat1
        assign pipe_out = arr_rdata;
    end else begin : g_latn
        sram_data_t dly_q [READ_LAT-1];

        always_ff @(posedge clk) begin
            dly_q[0] <= arr_rdata;
            for (int i = 1; i < READ_LAT - 1; i++) begin
                dly_q[i] <= dly_q[i-1];
            end
        end

        assign pipe_out = dly_q[READ_LAT-2];
    end

    // NOTE: every variable gets a value before any condition, so no path through
    // this block leaves a signal unassigned and no latch is inferred.
    always_comb begin
        rd_vld_d    = '0;
        rd_vld_d[0] = cmd.rd;
        for (int i = 1; i < READ_LAT; i++) begin
            rd_vld_d[i] = rd_vld_q[i-1];
        end
        dq_d       = rd_vld_q[READ_LAT-1] ? pipe_out : dq_q;
        rd_count_d = sat_inc(rd_count_q, cmd.rd);
        wr_count_d = sat_inc(wr_count_q, cmd.wr);
        err_d      = err_q | cmd.conflict;
    end

    // NOTE: non-blocking assignments here so every register samples the
    // pre-edge value of its neighbours, independent of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_vld_q   <= '0;
            dq_q       <= '0;
            rd_count_q <= '0;
            wr_count_q <= '0;
            err_q      <= 1'b0;
        end else begin
            rd_vld_q   <= rd_vld_d;
            dq_q       <= dq_d;
            rd_count_q <= rd_count_d;
            wr_count_q <= wr_count_d;
            err_q      <= err_d;
        end
    end

    // Lane drivers follow the live pins so OE/byte-enable changes act without a clock.
    assign drive_en = rst & cmd.rd;

    assign SRAM_DQ[SRAM_DATA_W-1:SRAM_LANE_W] = (drive_en && !bus.SRAM_UB_N) ?
        dq_q[SRAM_DATA_W-1:SRAM_LANE_W] : {SRAM_LANE_W{1'bz}};
    assign SRAM_DQ[SRAM_LANE_W-1:0] = (drive_en && !bus.SRAM_LB_N) ?
        dq_q[SRAM_LANE_W-1:0] : {SRAM_LANE_W{1'bz}};

    assign rd_count       = rd_count_q;
    assign wr_count       = wr_count_q;
    assign contention_err = err_q;

endmodule

// File: tb/tb_sram_responder.sv
// Scoreboard bench: two responders (READ_LAT 1 and 3) share one pin set; each
// has its own pulled-up DQ bus so a released lane reads back as all ones.
module tb_sram_responder;
    import sram_pkg::*;

    localparam int AW = 12;

    typedef struct {
        int          due;
        logic [15:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        tb_drv;
    logic [15:0] tb_dq;
    tri1  [15:0] dq1;
    tri1  [15:0] dq3;
    sram_cnt_t   rd1, wr1, rd3, wr3;
    logic        err1, err3;

    int          n_vec    = 0;
    int          n_err    = 0;
    int          edge_cnt = 0;
    exp_t        q1[$];
    exp_t        q3[$];
    logic [15:0] md1, md3, m_rd, m_wr;
    logic        m_err;
    logic [15:0] mem_m [int];

    sram_responder_if bus ();

    always #5 clk = ~clk;

    assign dq1 = tb_drv ? tb_dq : 16'hzzzz;
    assign dq3 = tb_drv ? tb_dq : 16'hzzzz;

    sram_responder #(.MEM_AW(AW), .READ_LAT(1)) u_dut_lat1 (
        .clk            (clk),
        .rst            (rst),
        .bus            (bus),
        .SRAM_DQ        (dq1),
        .rd_count       (rd1),
        .wr_count       (wr1),
        .contention_err (err1)
    );

    sram_responder #(.MEM_AW(AW), .READ_LAT(3)) u_dut_lat3 (
        .clk            (clk),
        .rst            (rst),
        .bus            (bus),
        .SRAM_DQ        (dq3),
        .rd_count       (rd3),
        .wr_count       (wr3),
        .contention_err (err3)
    );

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (edge %0d)", tag, got, exp, edge_cnt);
        end
    endtask

    function automatic logic [15:0] exp_bus(input logic [15:0] md);
        logic        drv;
        logic [15:0] rel;
        logic [15:0] res;
        drv = rst && !bus.SRAM_CE_N && !bus.SRAM_OE_N && bus.SRAM_WE_N;
        rel = tb_drv ? tb_dq : 16'hFFFF;
        res[15:8] = (drv && !bus.SRAM_UB_N) ? md[15:8] : rel[15:8];
        res[7:0]  = (drv && !bus.SRAM_LB_N) ? md[7:0]  : rel[7:0];
        return res;
    endfunction

    task automatic set_pins(input logic ce_n, input logic we_n, input logic oe_n,
                            input logic ub_n, input logic lb_n, input logic [17:0] addr,
                            input logic drv, input logic [15:0] wdata);
        bus.SRAM_CE_N = ce_n;
        bus.SRAM_WE_N = we_n;
        bus.SRAM_OE_N = oe_n;
        bus.SRAM_UB_N = ub_n;
        bus.SRAM_LB_N = lb_n;
        bus.SRAM_ADDR = addr;
        tb_drv        = drv;
        tb_dq         = wdata;
    endtask

    // Retire results whose output edge has passed, then compare what is visible now.
    task automatic observe(input bit chk);
        while (q1.size() > 0 && q1[0].due <= edge_cnt) md1 = q1.pop_front().data;
        while (q3.size() > 0 && q3[0].due <= edge_cnt) md3 = q3.pop_front().data;
        if (chk) begin
            check("dq_lat1", dq1, exp_bus(md1));
            check("dq_lat3", dq3, exp_bus(md3));
            check("rd_count_lat1", rd1, m_rd);
            check("rd_count_lat3", rd3, m_rd);
            check("wr_count_lat1", wr1, m_wr);
            check("wr_count_lat3", wr3, m_wr);
            check("contention_lat1", {15'd0, err1}, {15'd0, m_err});
            check("contention_lat3", {15'd0, err3}, {15'd0, m_err});
        end
    endtask

    task automatic model_edge();
        int          idx;
        logic [15:0] cur;
        logic [15:0] bus_v;
        edge_cnt++;
        idx = int'(bus.SRAM_ADDR[AW-1:0]);
        if (!bus.SRAM_CE_N && !bus.SRAM_WE_N) begin
            bus_v = tb_drv ? tb_dq : 16'hFFFF;
            cur   = mem_m.exists(idx) ? mem_m[idx] : 16'h0000;
            if (!bus.SRAM_UB_N) cur[15:8] = bus_v[15:8];
            if (!bus.SRAM_LB_N) cur[7:0]  = bus_v[7:0];
            mem_m[idx] = cur;
            if (m_wr != 16'hFFFF) m_wr++;
            if (!bus.SRAM_OE_N) m_err = 1'b1;
        end else if (!bus.SRAM_CE_N && !bus.SRAM_OE_N) begin
            q1.push_back('{due: edge_cnt + 1, data: mem_m[idx]});
            q3.push_back('{due: edge_cnt + 3, data: mem_m[idx]});
            if (m_rd != 16'hFFFF) m_rd++;
        end
    endtask

    task automatic step(input logic ce_n, input logic we_n, input logic oe_n,
                        input logic ub_n, input logic lb_n, input logic [17:0] addr,
                        input logic drv, input logic [15:0] wdata, input bit chk);
        set_pins(ce_n, we_n, oe_n, ub_n, lb_n, addr, drv, wdata);
        @(negedge clk);
        observe(chk);
        @(posedge clk);
        model_edge();
        #2;
    endtask

    task automatic wr(input logic [17:0] addr, input logic [15:0] data,
                      input logic ub_n, input logic lb_n);
        step(1'b0, 1'b0, 1'b1, ub_n, lb_n, addr, 1'b1, data, 1'b1);
    endtask

    task automatic rd(input logic [17:0] addr, input logic ub_n, input logic lb_n);
        step(1'b0, 1'b1, 1'b0, ub_n, lb_n, addr, 1'b0, 16'h0000, 1'b1);
    endtask

    task automatic idle();
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 18'h0, 1'b0, 16'h0000, 1'b1);
    endtask

    // Assert reset mid-cycle, try a write and a read while held, release after two edges.
    task automatic do_reset();
        rst = 1'b0;
        q1.delete();
        q3.delete();
        md1   = 16'h0000;
        md3   = 16'h0000;
        m_rd  = 16'h0000;
        m_wr  = 16'h0000;
        m_err = 1'b0;
        set_pins(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 18'h00010, 1'b1, 16'h1111);
        @(negedge clk);
        observe(1'b1);
        @(posedge clk);
        #2;
        set_pins(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 18'h00010, 1'b0, 16'h0000);
        @(negedge clk);
        observe(1'b1);
        @(posedge clk);
        #2;
        rst = 1'b1;
        set_pins(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 18'h0, 1'b0, 16'h0000);
    endtask

    initial begin
        rst = 1'b0;
        set_pins(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 18'h0, 1'b0, 16'h0000);
        md1   = 16'h0000;
        md3   = 16'h0000;
        m_rd  = 16'h0000;
        m_wr  = 16'h0000;
        m_err = 1'b0;
        #2;
        do_reset();
        idle();
        idle();

        // Write then immediate read, followed by reads of differing data to pin down latency.
        wr(18'h00010, 16'hA5C3, 1'b0, 1'b0);
        rd(18'h00010, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) rd(18'h00010, 1'b0, 1'b0);
        wr(18'h00011, 16'h5A3C, 1'b0, 1'b0);
        wr(18'h00012, 16'h0F0F, 1'b0, 1'b0);
        rd(18'h00011, 1'b0, 1'b0);
        rd(18'h00012, 1'b0, 1'b0);
        rd(18'h00010, 1'b0, 1'b0);
        rd(18'h00011, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) rd(18'h00012, 1'b0, 1'b0);

        // Single-lane output enables.
        rd(18'h00010, 1'b1, 1'b0);
        rd(18'h00010, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) rd(18'h00010, 1'b0, 1'b0);

        // Byte-lane write merge.
        wr(18'h00005, 16'h1234, 1'b0, 1'b0);
        wr(18'h00005, 16'hFF00, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) rd(18'h00005, 1'b0, 1'b0);

        // Upper address bits alias.
        wr(18'h01003, 16'hBEEF, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) rd(18'h00003, 1'b0, 1'b0);

        // Both lanes disabled: memory untouched, still counted.
        wr(18'h00005, 16'h0000, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) rd(18'h00005, 1'b0, 1'b0);

        // Chip disabled: nothing sampled even with WE_N/OE_N low.
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 18'h00005, 1'b1, 16'hDEAD, 1'b1);
        for (int i = 0; i < 4; i++) rd(18'h00005, 1'b0, 1'b0);

        // WE_N and OE_N both low: a write that must not drive DQ, sets the sticky flag.
        for (int i = 0; i < 3; i++) rd(18'h00010, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 18'h00020, 1'b0, 16'h0000, 1'b1);
        for (int i = 0; i < 3; i++) idle();
        for (int i = 0; i < 4; i++) rd(18'h00020, 1'b0, 1'b0);
        rd(18'h00010, 1'b0, 1'b0);
        idle();

        // Read in flight when reset hits; no stale word may surface afterwards.
        rd(18'h00011, 1'b0, 1'b0);
        do_reset();
        for (int i = 0; i < 5; i++) rd(18'h00010, 1'b0, 1'b0);

        // Write counter saturation.
        for (int i = 0; i < 65534; i++) begin
            step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 18'h00040, 1'b1, 16'(i), 1'b0);
        end
        for (int i = 0; i < 3; i++) wr(18'h00040, 16'hC0DE, 1'b0, 1'b0);
        idle();
        rd(18'h00040, 1'b0, 1'b0);
        rd(18'h00040, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) rd(18'h00040, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sram_responder.md
SRAM_RESPONDER -- requirements
Module: sram_responder

Interface
REQ-001 Parameter MEM_AW, default 12, SHALL set the number of implemented word-address bits (2^MEM_AW x 16-bit words).
REQ-002 Parameter READ_LAT, default 1, legal 1..4, SHALL set the number of clk edges from read sampling to DQ data update.
REQ-003 clk  input  1  single clock for the block; all state changes on the rising edge.
REQ-004 rst  input  1  reset, asynchronous assert, active-low (0 = reset).
REQ-005 SRAM_DQ  inout  16  data bus; sampled on writes, driven on reads, high-Z otherwise.
REQ-006 SRAM_ADDR  input  18  word address from the controller.
REQ-007 SRAM_UB_N  input  1  upper byte lane enable [15:8], active-low.
REQ-008 SRAM_LB_N  input  1  lower byte lane enable [7:0], active-low.
REQ-009 SRAM_WE_N  input  1  write enable, active-low.
REQ-010 SRAM_CE_N  input  1  chip enable, active-low.
REQ-011 SRAM_OE_N  input  1  output enable, active-low.
REQ-012 rd_count  output  16  number of sampled read cycles, saturating.
REQ-013 wr_count  output  16  number of sampled write cycles, saturating.
REQ-014 contention_err  output  1  sticky flag: WE_N and OE_N both low while CE_N low.

Function
REQ-015 Write cycle SHALL be sampled at a rising edge when CE_N=0 and WE_N=0; each lane with its enable low SHALL be written from SRAM_DQ, other lanes unchanged.
REQ-016 Read cycle SHALL be sampled at a rising edge when CE_N=0, WE_N=1 and OE_N=0; the addressed word enters a READ_LAT-deep pipeline.
REQ-017 Read data SHALL appear on the DQ output register exactly READ_LAT edges after sampling; the register holds its last value until the next pipeline output.
REQ-018 SRAM_DQ lane [15:8] SHALL be driven iff CE_N=0, OE_N=0, WE_N=1, UB_N=0 (combinational on current pins); lane [7:0] likewise with LB_N; else high-Z.
REQ-019 Only SRAM_ADDR[MEM_AW-1:0] SHALL be decoded; upper bits ignored (aliasing wrap-around).
REQ-020 Write at edge k followed by read of the same address sampled at edge k+1 SHALL return the newly written data.
REQ-021 CE_N=0 with WE_N=0 and OE_N=0 SHALL be treated as a write, SHALL NOT drive DQ, and SHALL set contention_err until reset.
REQ-022 CE_N=1 SHALL suppress all sampling regardless of WE_N/OE_N; the read pipeline still advances with invalid slots.
REQ-023 rd_count/wr_count SHALL increment by 1 per sampled read/write cycle and hold at 16'hFFFF (no wrap).
REQ-024 Byte-lane enables both high during a sampled write SHALL leave memory unchanged but still increment wr_count.

Reset
REQ-025 rst=0 SHALL asynchronously clear the read pipeline valid bits, the DQ output register (16'h0000), rd_count, wr_count and contention_err.
REQ-026 During reset SRAM_DQ SHALL be high-Z and no write SHALL occur.
REQ-027 Memory array contents SHALL NOT be cleared by reset; reset mid-read SHALL discard in-flight pipeline data.
REQ-028 Reset release SHALL take effect at the first rising edge with rst=1.

Structure
REQ-029 Shared package sram_pkg SHALL hold SRAM_ADDR_W=18, SRAM_DATA_W=16 and the READ_LAT default.
REQ-030 Byte-enabled storage SHALL be one sub-module, sram_resp_array (1 write port with 2 lane enables, 1 synchronous read port).
REQ-031 Pin decode, read pipeline, DQ tri-state, counters and error flag SHALL live in sram_responder.

Verification
REQ-032 Write 16'hA5C3 to addr 18'h00010 (UB_N=LB_N=0), read addr 18'h00010 with READ_LAT=1 -> DQ=16'hA5C3 one edge after sampling; wr_count=1, rd_count=1.
REQ-033 Write 16'h1234 to addr 5, then write 16'hFF00 with UB_N=0, LB_N=1, read addr 5 -> 16'hFF34.
REQ-034 MEM_AW=12: write 16'hBEEF to 18'h01003, read 18'h00003 -> 16'hBEEF (alias).
REQ-035 CE_N=0, WE_N=0, OE_N=0 for one edge -> DQ stays high-Z, contention_err=1 and stays 1 until rst=0.
REQ-036 READ_LAT=3: issue read, assert rst=0 after 1 edge, release -> DQ register=16'h0000, no stale data emitted, counters 0.
REQ-037 Preload wr_count to 16'hFFFE via 65534 writes, issue 3 more writes -> wr_count=16'hFFFF.
